// File: rtl/demux_collect.sv
// ---------------------------------------------------------------------------
// demux_collect
//
// Receive end of a serial lane fed by an N-to-1 bit multiplexer under a
// free-running select counter. Each accepted serial bit is steered into
// slot k of an assembly register, where k is the internal select counter
// (slot 0 = mux input a = LSB). When a whole frame has been collected the
// reassembled word is presented on a valid/ready output.
//
// Optional feature (compile-time macro DEMUX_PARITY_EN):
//   defined   - each frame carries WIDTH data bits plus one even-parity bit
//               in slot WIDTH; par_err flags a parity mismatch and is held
//               together with out_word.
//   undefined - frame is WIDTH bits, par_err is tied to 0.
//
// Parameters:
//   WIDTH  number of data slots per frame (power of two, 2..32)
//   SEL_W  slot counter width: clog2(WIDTH), or clog2(WIDTH+1) with parity
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_bit     serial data bit
//   in_valid   in_bit is valid this cycle
//   in_sync    frame-start marker (qualified by in_valid), carries slot 0
//   in_ready   collector accepts in_bit this cycle (combinational)
//   slot       slot the next accepted bit fills
//   out_word   reassembled word
//   out_valid  out_word holds an unconsumed word
//   out_ready  consumer takes out_word this cycle
//   frame_err  one-cycle pulse: in_sync arrived mid-frame
//   par_err    parity error for the current out_word
// ---------------------------------------------------------------------------
module demux_collect #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic             in_ready,
  output logic [SEL_W-1:0] slot,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             par_err
);

`ifdef DEMUX_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam int               IDX_W     = $clog2(WIDTH);
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LAST);

  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] merged;
  logic [IDX_W-1:0] idx;
  logic             at_last;
  logic             accept;

  // Data slots always fit in the low IDX_W bits; the parity slot (if any)
  // never writes the assembly register, so the truncation is safe.
  assign idx     = slot[IDX_W-1:0];
  assign at_last = (slot == LAST_SLOT);

  // Only the frame-completing bit has to wait for the consumer; every
  // earlier bit can be collected while the previous word is still pending.
  assign in_ready = !(at_last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  // Word presented on completion: without parity the completing bit is the
  // MSB data bit and is merged here, with parity it is the parity bit and
  // the data bits are already all in the assembly register.
  always_comb begin
    merged = asm_q;
`ifndef DEMUX_PARITY_EN
    merged[WIDTH-1] = in_bit;
`endif
  end

`ifdef DEMUX_PARITY_EN
  logic par_q;
  assign par_err = par_q;
`else
  assign par_err = 1'b0;
`endif

  // Slot counter, assembly register and output register. A sync marker
  // restarts the frame from whatever slot we were in; a completion on the
  // same edge as a consumer handshake keeps out_valid high with new data.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot      <= '0;
      asm_q     <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef DEMUX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (in_sync) begin
          asm_q[0] <= in_bit;
          slot     <= SEL_W'(1);
          if (slot != '0) begin
            frame_err <= 1'b1;
          end
        end else if (at_last) begin
          slot      <= '0;
          out_word  <= merged;
          out_valid <= 1'b1;
`ifdef DEMUX_PARITY_EN
          par_q     <= (^asm_q) ^ in_bit;
`endif
        end else begin
          asm_q[idx] <= in_bit;
          slot       <= slot + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_collect.sv
// ---------------------------------------------------------------------------
// tb_demux_collect
//
// Scoreboard bench for demux_collect. The driver issues serial bits and
// keeps a frame-level reference model (a queue of received bits); each
// completed frame pushes its expected word into a scoreboard queue. A
// separate monitor compares the DUT outputs against the model on every
// falling edge and pops the scoreboard whenever a word is consumed.
// Honours DEMUX_PARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_demux_collect;

  localparam int WIDTH = 8;
`ifdef DEMUX_PARITY_EN
  localparam int SEL_W = $clog2(WIDTH + 1);
  localparam int FRAME = WIDTH + 1;
`else
  localparam int SEL_W = $clog2(WIDTH);
  localparam int FRAME = WIDTH;
`endif
  localparam int LAST = FRAME - 1;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic             perr;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_bit;
  logic             in_valid;
  logic             in_sync;
  logic             in_ready;
  logic [SEL_W-1:0] slot;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             out_ready;
  logic             frame_err;
  logic             par_err;

  // Reference model state
  logic frame_bits[$];
  exp_t exp_q[$];
  logic exp_ferr = 1'b0;
  logic mon_en   = 1'b0;

  int check_count = 0;
  int pass_count  = 0;

  demux_collect #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_sync   (in_sync),
    .in_ready  (in_ready),
    .slot      (slot),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    check_count++;
    if (act == exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic modelReady(input logic rdy);
    return !((frame_bits.size() == LAST) && (exp_q.size() > 0) && !rdy);
  endfunction

  // Frame-level model: a sync restarts the bit list, a full list becomes
  // an expected word (bits in arrival order, first bit = LSB) and the
  // parity check is simply the XOR of every bit in the frame.
  task automatic modelEdge(input logic v, input logic b, input logic s,
                           input logic r, input logic acc);
    exp_t e;
    exp_ferr = 1'b0;
    if (r) begin
      frame_bits.delete();
      exp_q.delete();
    end else if (v && acc) begin
      if (s) begin
        if (frame_bits.size() != 0) exp_ferr = 1'b1;
        frame_bits.delete();
      end
      frame_bits.push_back(b);
      if (frame_bits.size() == FRAME) begin
        e.word = '0;
        e.perr = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          if (frame_bits[i]) e.word = e.word | (WIDTH'(1) << i);
        end
`ifdef DEMUX_PARITY_EN
        for (int i = 0; i < FRAME; i++) e.perr = e.perr ^ frame_bits[i];
`endif
        exp_q.push_back(e);
        frame_bits.delete();
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic applyStimulus(input logic v, input logic b, input logic s,
                               input logic rdy, input logic r,
                               output logic acc);
    reset     = r;
    in_valid  = v;
    in_bit    = b;
    in_sync   = s;
    out_ready = rdy;
    acc = v && modelReady(rdy) && !r;
    @(posedge clk);
    modelEdge(v, b, s, r, acc);
    #1;
  endtask

  task automatic doReset();
    logic acc;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    mon_en = 1'b1;
    #2;
    checkOutput("rst_out_word", int'(out_word), 0);
    checkOutput("rst_par_err", int'(par_err), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_slot", int'(slot), 0);
  endtask

  // Keep offering a bit until it is taken; after a few stalled cycles the
  // consumer is forced ready so the wait is always bounded.
  task automatic sendBit(input logic b, input logic s, input logic rdy);
    logic acc;
    logic r_now;
    int   stalls;
    stalls = 0;
    r_now  = rdy;
    acc    = 1'b0;
    while (!acc && stalls < 20) begin
      applyStimulus(1'b1, b, s, r_now, 1'b0, acc);
      if (!acc) begin
        stalls++;
        if (stalls >= 3) r_now = 1'b1;
      end
    end
    if (!acc) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic sendFrame(input logic [WIDTH-1:0] w, input logic flip_par,
                           input logic rdy);
    logic b;
    for (int i = 0; i < FRAME; i++) begin
      b = (i < WIDTH) ? w[i] : ((^w) ^ flip_par);
      sendBit(b, i == 0, rdy);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, rdy, 1'b0, acc);
  endtask

  // Monitor: compare DUT state with the model every falling edge, and pop
  // the scoreboard whenever the consumer takes a word.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("slot", int'(slot), frame_bits.size());
      checkOutput("in_ready", int'(in_ready), int'(modelReady(out_ready)));
      checkOutput("frame_err", int'(frame_err), int'(exp_ferr));
      checkOutput("out_valid", int'(out_valid), int'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        if (out_valid) begin
          checkOutput("out_word", int'(out_word), int'(exp_q[0].word));
          checkOutput("par_err", int'(par_err), int'(exp_q[0].perr));
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic acc;
    logic v, b, s, rdy, r;
    reset     = 1'b1;
    in_bit    = 1'b0;
    in_valid  = 1'b0;
    in_sync   = 1'b0;
    out_ready = 1'b0;
    #1;
    doReset();

    // Frame 0xA5 held, then 0x3C streamed under backpressure.
    sendFrame(8'hA5, 1'b0, 1'b0);
    idle(2, 1'b0);
    sendFrame(8'h3C, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Back-to-back frames with a permanently ready consumer.
    sendFrame(8'hFF, 1'b0, 1'b1);
    sendFrame(8'h00, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Sync arriving mid-frame restarts collection.
    sendBit(1'b1, 1'b1, 1'b1);
    sendBit(1'b1, 1'b0, 1'b1);
    sendBit(1'b0, 1'b0, 1'b1);
    sendBit(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < FRAME; i++) sendBit(1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Reset with a pending word and a partial frame.
    sendFrame(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) sendBit(i[0], i == 0, 1'b0);
    doReset();
    sendFrame(8'h5A, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Parity good and bad (flip is a no-op without the parity slot).
    sendFrame(8'hA5, 1'b0, 1'b1);
    sendFrame(8'hA5, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      b   = $urandom_range(0, 1) != 0;
      s   = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      r   = ($urandom_range(0, 99) == 0);
      applyStimulus(v, b, s, rdy, r, acc);
    end
    idle(4, 1'b1);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
